rect_fill_engine: RTL
=====================

# rect_fill_engine

Command-driven rectangle filler that writes solid-colour rectangles into the HDMI controller's frame buffer through its pixel write port (pixel address, pixel data, write enable). It sits directly upstream of the ADV7511 HDMI controller in the system clock domain and lets software or test logic paint the screen without producing pixels itself. It clips each rectangle to the frame and emits one pixel write per clock.

## Interface
- FB_WIDTH, 1280: frame buffer width in pixels.
- FB_HEIGHT, 720: frame buffer height in lines.
- DATA_W, 16: pixel width; matches the controller's 16-bit HDMI_D word.
- X_W, $clog2(FB_WIDTH): coordinate and width field size (11).
- Y_W, $clog2(FB_HEIGHT): line and height field size (10).
- ADDR_W, $clog2(FB_WIDTH*FB_HEIGHT): pixel address width (20).
- clk_i  in  1  system clock, the same clock as the controller's clk_i.
- rst_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine can accept a command.
- cmd_x0_i  in  X_W  left column.
- cmd_y0_i  in  Y_W  top line.
- cmd_w_i  in  X_W+1  width in pixels.
- cmd_h_i  in  Y_W+1  height in lines.
- cmd_colour_i  in  DATA_W  fill value.
- pxl_addr_o  out  ADDR_W  write address, computed as y*FB_WIDTH+x.
- pxl_data_o  out  DATA_W  write data.
- pxl_en_o  out  1  write strobe, one pixel per cycle it is high.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready_o=1. The engine accepts a command on a rising edge where cmd_valid_i and cmd_ready_o are both 1, latches all command fields, and moves to SETUP.
- SETUP lasts one cycle and does three things:
  - Clips the width: w_eff = min(w, FB_WIDTH-x0).
  - Clips the height: h_eff = min(h, FB_HEIGHT-y0).
  - Computes base = y0*FB_WIDTH+x0 using a single registered multiply.
- SETUP exit: if x0≥FB_WIDTH, y0≥FB_HEIGHT, w=0 or h=0, the command is dropped and the FSM goes to DONE with no writes. Otherwise it goes to FILL.
- FILL writes every cycle:
  - pxl_en_o=1, pxl_data_o = latched colour, pxl_addr_o = running address.
  - Column counter cx counts 0..w_eff-1. Address increments by 1 each pixel.
  - At cx=w_eff-1 and cy<h_eff-1: cx clears, cy increments, address += FB_WIDTH-w_eff+1.
  - At cx=w_eff-1 and cy=h_eff-1: this is the last write, and the next state is DONE.
- DONE lasts one cycle: done_o=1, cmd_ready_o=0, then IDLE.
- While busy, cmd_valid_i is ignored and the command fields may change freely. Commands are never queued.
- The fill colour is a don't-care to the engine. It writes the value unmodified, in the controller's 16-bit format.
- Width rule: all address arithmetic is ADDR_W unsigned, with no wrap. Clipping guarantees the address never exceeds FB_WIDTH*FB_HEIGHT-1.

## Timing
- Reset values: cmd_ready_o=0 while rst_n_i=0, then 1 on the first clock in IDLE. All other outputs are 0, including pxl_addr_o and pxl_data_o.
- Reset mid-FILL: pxl_en_o drops immediately, without waiting for a clock, and the FSM returns to IDLE. The partial rectangle is not resumed.
- All outputs are registered; there is no combinational path from the cmd_* inputs to any output.
- Accept edge k: SETUP is cycle k+1 and the first pxl_en_o is cycle k+2.
- The last write is cycle k+1+w_eff*h_eff. done_o follows in the next cycle, and cmd_ready_o returns the cycle after that.
- A dropped command pulses done_o in cycle k+2.
- Minimum command period is w_eff*h_eff+3 cycles. pxl_en_o is never deasserted inside one rectangle.

## Structure
- A shared package rect_fill_pkg holds:
  - the state enum (IDLE, SETUP, FILL, DONE);
  - the command struct rect_cmd_t with fields x0, y0, w, h, colour;
  - the FB_WIDTH/FB_HEIGHT defaults used by both this block and the HDMI controller.
- The only natural sub-module is rect_clip, a combinational-plus-register stage used in SETUP. It produces w_eff, h_eff, base and drop.
- Everything else is one FSM with its counters.

## Test plan
All scenarios use FB_WIDTH=1280 and FB_HEIGHT=720.
- Basic fill: x0=10, y0=2, w=3, h=2, colour=16'h8080.
  - Writes addresses 2570, 2571, 2572, 3850, 3851, 3852, all with data 8080, on consecutive cycles k+2..k+7.
  - done_o pulses at k+8.
- Right-edge clip: x0=1278, y0=0, w=5, h=1. Only addresses 1278 and 1279 are written, then done_o.
- Degenerate commands: w=0, then x0=1280, then y0=720. Each produces zero pxl_en_o and a done_o pulse at k+2.
- Full screen: x0=0, y0=0, w=1280, h=720.
  - Exactly 921600 writes, with addresses 0..921599 strictly consecutive.
  - done_o pulses at k+921602.
- Busy handshake: hold cmd_valid_i=1 with a second command during a fill. The second command is accepted only on the edge after done_o, and its fields are sampled at that edge.
- Reset mid-fill: drop rst_n_i for 3 cycles during a 4x4 fill.
  - pxl_en_o falls without waiting for a clock, and there is no done_o pulse.
  - cmd_ready_o=1 on the first clock after release, and a new command then runs normally.

Source files
------------

// File: rtl/rect_fill_pkg.sv
// Shared types for the rectangle filler and the HDMI frame buffer side.
// Holds frame size defaults, FSM state enum and the command bundle.
package rect_fill_pkg;

   localparam int FB_WIDTH_DEF  = 1280;
   localparam int FB_HEIGHT_DEF = 720;
   localparam int CMD_DATA_W    = 16;
   localparam int CMD_X_W       = $clog2(FB_WIDTH_DEF);
   localparam int CMD_Y_W       = $clog2(FB_HEIGHT_DEF);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } rf_state_e;

   typedef struct packed {
      logic [CMD_X_W-1:0]    x0;
      logic [CMD_Y_W-1:0]    y0;
      logic [CMD_X_W:0]      w;
      logic [CMD_Y_W:0]      h;
      logic [CMD_DATA_W-1:0] colour;
   } rect_cmd_t;

endpackage

// File: rtl/rect_fill_engine_clip.sv
// Clip stage: trims a latched command to the frame.
// Ports: clk_i/rst_n_i, load_i (SETUP), cmd_i; drop_o and base_o are
// combinational, w_eff_o/h_eff_o are registered on load_i.
module rect_clip
   import rect_fill_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF,
   parameter int X_W       = $clog2(FB_WIDTH),
   parameter int Y_W       = $clog2(FB_HEIGHT),
   parameter int ADDR_W    = $clog2(FB_WIDTH*FB_HEIGHT)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  rect_cmd_t         cmd_i,
   output logic              drop_o,
   output logic [ADDR_W-1:0] base_o,
   output logic [X_W:0]      w_eff_o,
   output logic [Y_W:0]      h_eff_o
);

   logic [X_W:0] x0_ext;
   logic [Y_W:0] y0_ext;
   logic [X_W:0] rem_x;
   logic [Y_W:0] rem_y;

   always_comb begin
      x0_ext = {1'b0, cmd_i.x0};
      y0_ext = {1'b0, cmd_i.y0};
      // Remaining room is only meaningful when the origin is on-screen;
      // off-screen origins are dropped before it is ever used.
      rem_x  = (X_W+1)'(FB_WIDTH) - x0_ext;
      rem_y  = (Y_W+1)'(FB_HEIGHT) - y0_ext;
      drop_o = (x0_ext >= (X_W+1)'(FB_WIDTH))
             | (y0_ext >= (Y_W+1)'(FB_HEIGHT))
             | (cmd_i.w == '0)
             | (cmd_i.h == '0);
      base_o = ADDR_W'(cmd_i.y0) * ADDR_W'(FB_WIDTH)
             + ADDR_W'(cmd_i.x0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         w_eff_o <= '0;
         h_eff_o <= '0;
      end else if (load_i) begin
         w_eff_o <= (cmd_i.w < rem_x) ? cmd_i.w : rem_x;
         h_eff_o <= (cmd_i.h < rem_y) ? cmd_i.h : rem_y;
      end
   end

endmodule

// File: rtl/rect_fill_engine.sv
// Command-driven solid rectangle filler feeding the frame buffer write port.
// Ports: cmd_* valid/ready command in; pxl_addr/data/en out; busy_o, done_o.
module rect_fill_engine
   import rect_fill_pkg::*;
#(
   parameter int FB_WIDTH  = FB_WIDTH_DEF,
   parameter int FB_HEIGHT = FB_HEIGHT_DEF,
   parameter int DATA_W    = CMD_DATA_W,
   parameter int X_W       = $clog2(FB_WIDTH),
   parameter int Y_W       = $clog2(FB_HEIGHT),
   parameter int ADDR_W    = $clog2(FB_WIDTH*FB_HEIGHT)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [X_W-1:0]    cmd_x0_i,
   input  logic [Y_W-1:0]    cmd_y0_i,
   input  logic [X_W:0]      cmd_w_i,
   input  logic [Y_W:0]      cmd_h_i,
   input  logic [DATA_W-1:0] cmd_colour_i,
   output logic [ADDR_W-1:0] pxl_addr_o,
   output logic [DATA_W-1:0] pxl_data_o,
   output logic              pxl_en_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [X_W:0]      CX_ONE = (X_W+1)'(1);
   localparam logic [Y_W:0]      CY_ONE = (Y_W+1)'(1);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

   rf_state_e         state_q;
   rf_state_e         state_d;
   rect_cmd_t         cmd_q;
   logic              accept;
   logic              drop;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] row_step;
   logic [X_W:0]      w_eff;
   logic [Y_W:0]      h_eff;
   logic [X_W:0]      cx;
   logic [Y_W:0]      cy;
   logic              cx_last;
   logic              last;
   logic              ready_d;
   logic              busy_d;
   logic              done_d;

   rect_clip #(
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT),
      .X_W       (X_W),
      .Y_W       (Y_W),
      .ADDR_W    (ADDR_W)
   ) u_clip (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (state_q == SETUP),
      .cmd_i   (cmd_q),
      .drop_o  (drop),
      .base_o  (base),
      .w_eff_o (w_eff),
      .h_eff_o (h_eff)
   );

   assign accept  = (state_q == IDLE) & cmd_valid_i & cmd_ready_o;
   assign cx_last = (cx + CX_ONE) == w_eff;
   assign last    = cx_last & ((cy + CY_ONE) == h_eff);
   // Jump from the last pixel of a row to the first of the next one.
   assign row_step = ADDR_W'(FB_WIDTH) - ADDR_W'(w_eff) + A_ONE;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept) state_d = SETUP;
         SETUP: state_d = drop ? DONE : FILL;
         FILL:  if (last) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Status outputs are registered from the next state so they line
      // up with the state they describe.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cmd_ready_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         cmd_ready_o <= ready_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cmd_q      <= '0;
         cx         <= '0;
         cy         <= '0;
         pxl_addr_o <= '0;
         pxl_data_o <= '0;
         pxl_en_o   <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q <= '{x0:     cmd_x0_i,
                       y0:     cmd_y0_i,
                       w:      cmd_w_i,
                       h:      cmd_h_i,
                       colour: cmd_colour_i};
         end
         if (state_q == SETUP && !drop) begin
            pxl_en_o   <= 1'b1;
            pxl_addr_o <= base;
            pxl_data_o <= cmd_q.colour;
            cx         <= '0;
            cy         <= '0;
         end else if (state_q == FILL) begin
            if (last) begin
               pxl_en_o <= 1'b0;
            end else if (cx_last) begin
               cx         <= '0;
               cy         <= cy + CY_ONE;
               pxl_addr_o <= pxl_addr_o + row_step;
            end else begin
               cx         <= cx + CX_ONE;
               pxl_addr_o <= pxl_addr_o + A_ONE;
            end
         end
      end
   end

endmodule
